// File: rtl/dist_uart_pkg.sv
// Shared types and constants for the distance-to-UART ASCII record path.
package dist_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        SEND
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Largest value representable in 'digits' decimal digits (10^digits - 1).
    function automatic int unsigned clamp_max(input int unsigned digits);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/dist_ascii_tx_bin2bcd_iter.sv
// Iterative double-dabble: one add-3/shift step per clock, DIST_W steps per conversion.
module bin2bcd_iter #(
    parameter int DIST_W     = 10,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DIST_W-1:0]       bin,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int CNT_W = $clog2(DIST_W + 1);
    localparam int BCD_W = 4 * NUM_DIGITS;

    logic [DIST_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BCD_W-1:0]  adj;

    // NOTE: every variable gets a default before the loop so the block stays purely combinational (no latch).
    always_comb begin
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd     <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (start) begin
            bcd     <= '0;
            shift_q <= bin;
            cnt_q   <= CNT_W'(DIST_W);
        end else if (cnt_q != '0) begin
            bcd     <= {adj[BCD_W-2:0], shift_q[DIST_W-1]};
            shift_q <= shift_q << 1;
            cnt_q   <= cnt_q - 1'b1;
        end
    end

    // High during the cycle whose closing edge performs the final shift, so the
    // consumer sees a complete result in the very next cycle.
    assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/dist_ascii_tx.sv
// Converts a binary distance sample to a fixed-width ASCII record (digits, CR, LF)
// and writes it byte by byte into the UART TX FIFO.
module dist_ascii_tx
    import dist_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIST_W     = 10,
    parameter int NUM_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIST_W-1:0]     dist_in,
    input  logic                  dist_valid,
    input  logic                  tx_full,
    output logic                  wr_uart,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  busy,
    output logic                  drop
);

    localparam int unsigned MAX_DEC = clamp_max(NUM_DIGITS);
    localparam int          IDX_W   = $clog2(NUM_DIGITS + 2);
    localparam int          BCD_W   = 4 * NUM_DIGITS;
    localparam logic [IDX_W-1:0] CR_IDX   = IDX_W'(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS + 1);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic              start;
    logic              conv_done;
    logic [DIST_W-1:0] dist_clamped;
    logic [BCD_W-1:0]  bcd;
    logic [3:0]        digit;
    logic              lead;

    assign start   = (state == IDLE) && dist_valid;
    assign busy    = (state != IDLE);
    assign wr_uart = (state == SEND) && !tx_full;

    // Values beyond the record width saturate rather than wrap.
    always_comb begin
        dist_clamped = dist_in;
        if (32'(dist_in) > MAX_DEC) begin
            dist_clamped = MAX_DEC[DIST_W-1:0];
        end
    end

    bin2bcd_iter #(
        .DIST_W    (DIST_W),
        .NUM_DIGITS(NUM_DIGITS)
    ) u_bin2bcd (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .bin  (dist_clamped),
        .done (conv_done),
        .bcd  (bcd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
            drop  <= 1'b0;
        end else begin
            drop <= dist_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (dist_valid) begin
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (conv_done) begin
                        state <= SEND;
                        idx   <= '0;
                    end
                end
                SEND: begin
                    // A stalled FIFO holds the index, so each byte is written exactly once.
                    if (wr_uart) begin
                        if (idx == LAST_IDX) begin
                            state <= IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Digits scan most significant first; 'lead' stays set while only zeros have been seen.
    always_comb begin
        w_data = '0;
        digit  = '0;
        lead   = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit = bcd[BCD_W-1-4*i -: 4];
            if (digit != 4'd0) begin
                lead = 1'b0;
            end
            if ((state == SEND) && (idx == IDX_W'(i))) begin
                w_data = (lead && (i != NUM_DIGITS - 1)) ? DATA_WIDTH'(ASCII_SPACE)
                                                         : DATA_WIDTH'(ASCII_ZERO + {4'd0, digit});
            end
        end
        if (state == SEND) begin
            if (idx == CR_IDX) begin
                w_data = DATA_WIDTH'(ASCII_CR);
            end else if (idx == LAST_IDX) begin
                w_data = DATA_WIDTH'(ASCII_LF);
            end
        end
    end

endmodule

// File: tb/tb_dist_ascii_tx.sv
// Scoreboard bench for dist_ascii_tx: a default instance plus a DIST_W=14 instance for clamping.
module tb_dist_ascii_tx;

    localparam int ND       = 4;
    localparam int DIST_W   = 10;
    localparam int DIST_W_B = 14;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [DIST_W-1:0]   dist_in    = '0;
    logic                dist_valid = 1'b0;
    logic                tx_full    = 1'b0;
    logic                wr_uart;
    logic [7:0]          w_data;
    logic                busy;
    logic                drop;

    logic [DIST_W_B-1:0] dist_in_b    = '0;
    logic                dist_valid_b = 1'b0;
    logic                tx_full_b    = 1'b0;
    logic                wr_uart_b;
    logic [7:0]          w_data_b;
    logic                busy_b;
    logic                drop_b;

    dist_ascii_tx #(.DATA_WIDTH(8), .DIST_W(DIST_W), .NUM_DIGITS(ND)) dut (
        .clk(clk), .rst(rst), .dist_in(dist_in), .dist_valid(dist_valid), .tx_full(tx_full),
        .wr_uart(wr_uart), .w_data(w_data), .busy(busy), .drop(drop)
    );

    dist_ascii_tx #(.DATA_WIDTH(8), .DIST_W(DIST_W_B), .NUM_DIGITS(ND)) dut_b (
        .clk(clk), .rst(rst), .dist_in(dist_in_b), .dist_valid(dist_valid_b), .tx_full(tx_full_b),
        .wr_uart(wr_uart_b), .w_data(w_data_b), .busy(busy_b), .drop(drop_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_a = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int wr_edges_a[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference record: saturate to four decimal digits, right-justify with spaces, append CR LF.
    function automatic void model_record(input int unsigned v, output logic [7:0] r[ND+2]);
        int unsigned c;
        string s;
        c = (v > 9999) ? 9999 : v;
        s = $sformatf("%4d", c);
        for (int i = 0; i < ND; i++) r[i] = s[i];
        r[ND]   = 8'h0D;
        r[ND+1] = 8'h0A;
    endfunction

    // Monitors: each byte written into the FIFO is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (wr_uart) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_write: got %0h expected no write", w_data);
                end else begin
                    check("a_byte", w_data, exp_a.pop_front());
                end
                wr_edges_a.push_back(cyc + 1);
            end
            if (!busy) check("a_idle_outputs", {wr_uart, w_data}, 9'd0);
        end
    end

    always @(negedge clk) begin
        if (rst && wr_uart_b) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_write: got %0h expected no write", w_data_b);
            end else begin
                check("b_byte", w_data_b, exp_b.pop_front());
            end
        end
    end

    task automatic send_a(input int unsigned v);
        logic [7:0] r[ND+2];
        @(posedge clk); #1;
        dist_in    = DIST_W'(v);
        dist_valid = 1'b1;
        @(posedge clk); #1;
        dist_valid = 1'b0;
        strobe_a   = cyc;
        model_record(v, r);
        for (int i = 0; i < ND + 2; i++) exp_a.push_back(r[i]);
    endtask

    task automatic send_b(input int unsigned v);
        logic [7:0] r[ND+2];
        @(posedge clk); #1;
        dist_in_b    = DIST_W_B'(v);
        dist_valid_b = 1'b1;
        @(posedge clk); #1;
        dist_valid_b = 1'b0;
        model_record(v, r);
        for (int i = 0; i < ND + 2; i++) exp_b.push_back(r[i]);
    endtask

    // Returns at the first falling edge where the DUT is idle; an expired bound is a failure.
    task automatic wait_idle_a(input bit randomize_full);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            if (randomize_full) begin
                @(posedge clk); #1;
                tx_full = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL a_wait_idle_timeout: got busy=1 expected busy=0");
        end
    endtask

    task automatic wait_idle_b();
        int n;
        n = 0;
        @(negedge clk);
        while (busy_b && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy_b) begin
            checks++;
            errors++;
            $display("FAIL b_wait_idle_timeout: got busy=1 expected busy=0");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int n;
        int first_edge;
        // Reset state
        #1;
        check("reset_outputs", {wr_uart, w_data, busy, drop}, 11'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // 123: latency, back-to-back bytes, occupancy
        wr_edges_a.delete();
        send_a(123);
        @(negedge clk);
        check("busy_after_accept", busy, 1'b1);
        wait_idle_a(1'b0);
        check("occupancy_123", cyc - strobe_a, DIST_W + ND + 2);
        check("writes_123", wr_edges_a.size(), 6);
        if (wr_edges_a.size() == 6) begin
            check("latency_123", wr_edges_a[0] - strobe_a, DIST_W + 1);
            check("burst_123", wr_edges_a[5] - wr_edges_a[0], 5);
        end
        check("drained_123", exp_a.size(), 0);

        // Zero and full-scale inputs
        send_a(0);
        wait_idle_a(1'b0);
        send_a(1023);
        wait_idle_a(1'b0);
        check("drained_edges", exp_a.size(), 0);

        // 407 with a five-cycle stall while index 2 is presented
        wr_edges_a.delete();
        send_a(407);
        repeat (12) @(posedge clk);
        #1 tx_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_no_write", wr_uart, 1'b0);
            check("stall_holds_byte", w_data, 8'h30);
            @(posedge clk); #1;
        end
        tx_full = 1'b0;
        wait_idle_a(1'b0);
        check("writes_407", wr_edges_a.size(), 6);
        if (wr_edges_a.size() == 6) check("span_407", wr_edges_a[5] - wr_edges_a[0], 10);
        check("drained_407", exp_a.size(), 0);

        // Strobes while busy: during CONVERT and on the final-byte cycle
        send_a(200);
        repeat (3) @(posedge clk);
        #1;
        dist_in    = 10'd55;
        dist_valid = 1'b1;
        @(posedge clk); #1;
        dist_valid = 1'b0;
        @(negedge clk);
        check("drop_convert", drop, 1'b1);
        @(negedge clk);
        check("drop_one_cycle", drop, 1'b0);
        n = 0;
        while (!(wr_uart && w_data == 8'h0A) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("found_final_byte", {wr_uart, w_data}, {1'b1, 8'h0A});
        dist_in    = 10'd55;
        dist_valid = 1'b1;
        @(posedge clk); #1;
        dist_valid = 1'b0;
        @(negedge clk);
        check("drop_final", drop, 1'b1);
        check("idle_after_final", busy, 1'b0);
        repeat (20) @(negedge clk);
        check("drop_ignored_record", exp_a.size(), 0);
        send_a(55);
        wait_idle_a(1'b0);
        check("drained_after_drop", exp_a.size(), 0);

        // Asynchronous reset after two bytes
        wr_edges_a.delete();
        send_a(321);
        n = 0;
        while (wr_edges_a.size() < 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("two_bytes_before_reset", wr_edges_a.size(), 2);
        #3 rst = 1'b0;
        #1;
        check("reset_mid_record", {wr_uart, w_data, busy, drop}, 11'd0);
        exp_a.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("quiet_after_reset", wr_edges_a.size(), 2);
        send_a(321);
        wait_idle_a(1'b0);
        check("drained_after_reset", exp_a.size(), 0);

        // Randomized values with random FIFO back-pressure
        for (int k = 0; k < 20; k++) begin
            send_a($urandom_range(0, 1023));
            wait_idle_a(1'b1);
            tx_full = 1'b0;
        end
        check("drained_random", exp_a.size(), 0);

        // Wider input: clamping and boundaries
        send_b(12000);
        wait_idle_b();
        send_b(9999);
        wait_idle_b();
        send_b(10000);
        wait_idle_b();
        send_b(16383);
        wait_idle_b();
        for (int k = 0; k < 6; k++) begin
            send_b($urandom_range(0, 16383));
            wait_idle_b();
        end
        check("drained_b", exp_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dist_ascii_tx.md
Name: dist_ascii_tx

Overview:
Upstream feeder for the UART transmit path of the vga-uart top level. It accepts a binary ultrasonic distance sample (cm) from the measurement logic and converts it to decimal with an iterative double-dabble. It then pushes a fixed-length ASCII record, NUM_DIGITS characters followed by CR LF, into the UART TX FIFO through that FIFO's write/full interface.

Parameters:
DATA_WIDTH, 8, UART byte width; must equal the TX FIFO word width.
DIST_W, 10, width of the binary distance input.
NUM_DIGITS, 4, decimal digits emitted per record; record length is NUM_DIGITS+2 bytes.

Ports:
clk  in  1  system clock; sole clock domain.
rst  in  1  asynchronous, active-low reset (asserted when 0).
dist_in  in  DIST_W  binary distance in cm; sampled only when dist_valid=1 in IDLE.
dist_valid  in  1  single-cycle sample strobe.
tx_full  in  1  TX FIFO full flag.
wr_uart  out  1  TX FIFO write strobe; one byte per asserted cycle.
w_data  out  DATA_WIDTH  byte presented to the TX FIFO.
busy  out  1  high from acceptance until the last byte is written.
drop  out  1  one-cycle pulse when dist_valid arrives while busy.

Behaviour:
- Reset (rst=0, async): state IDLE; wr_uart=0, w_data=0, busy=0, drop=0; BCD, shift and index registers cleared.
- Reset mid-operation: the record is abandoned immediately. No further bytes are written after release, even though bytes already written remain in the FIFO.
- States: IDLE -> CONVERT -> SEND -> IDLE.
- IDLE, dist_valid=1 at edge t:
  - Latch dist_in, clamped to 10^NUM_DIGITS-1 if larger.
  - Clear BCD and go to CONVERT.
  - busy=1 from t+1.
- CONVERT: exactly DIST_W cycles (t+1..t+DIST_W). Each cycle:
  - every BCD nibble >=5 gets +3;
  - then {bcd,shift} shifts left by 1, MSB of shift entering bcd LSB.
  - A bit counter ends the phase; go to SEND at t+DIST_W+1 with byte index 0.
- SEND: index 0..NUM_DIGITS+1.
  - w_data is combinational from index:
    - digit bytes, most significant first, are 0x30+nibble;
    - leading zeros become 0x20 (space), except the least significant digit, which is always a numeral;
    - index NUM_DIGITS = 0x0D;
    - index NUM_DIGITS+1 = 0x0A.
  - wr_uart = (state==SEND) && !tx_full. This is combinational on tx_full; the FIFO samples wr_uart/w_data on the same edge.
  - Index advances only on edges where wr_uart=1. With tx_full=1 the index holds, so no skipped or duplicated bytes.
  - After the edge writing index NUM_DIGITS+1, go to IDLE; busy=0 next cycle.
- Unstalled timing: first write at t+DIST_W+1; NUM_DIGITS+2 consecutive writes; total occupancy DIST_W+NUM_DIGITS+2 cycles.
- dist_valid while busy (CONVERT or SEND, including the final-byte cycle): sample ignored, drop=1 for the following cycle, and the current record is unaffected.
- w_data is 0 whenever state != SEND.

Decomposition:
- Package dist_uart_pkg holds:
  - the state enum (IDLE, CONVERT, SEND);
  - ASCII constants ASCII_ZERO=0x30, ASCII_SPACE=0x20, ASCII_CR=0x0D, ASCII_LF=0x0A;
  - a function for the clamp value 10^NUM_DIGITS-1.
- One sub-module: bin2bcd_iter. It holds the double-dabble shift/add-3 datapath and bit counter, with a start/done handshake (done one-cycle pulse after DIST_W shifts) and output bcd[4*NUM_DIGITS-1:0]. The top FSM owns the handshake to the FIFO and the byte formatting.

Test Plan:
- dist_in=123, tx_full=0 -> first wr_uart 11 cycles after strobe; bytes 0x20 0x31 0x32 0x33 0x0D 0x0A on 6 consecutive cycles; busy low after.
- dist_in=0 -> bytes 0x20 0x20 0x20 0x30 0x0D 0x0A.
- dist_in=1023 -> bytes 0x31 0x30 0x32 0x33 0x0D 0x0A; with DIST_W=14, dist_in=12000 is clamped -> 0x39 0x39 0x39 0x39 0x0D 0x0A.
- dist_in=407, tx_full raised for 5 cycles while index=2 is presented -> wr_uart=0 during the stall; 0x30 written once after release; full record 0x20 0x34 0x30 0x37 0x0D 0x0A, no duplicates.
- Second dist_valid (dist_in=55) during CONVERT and again on the final-byte cycle -> drop pulses twice; only the first record is emitted; a new strobe in IDLE is accepted normally.
- rst driven to 0 asynchronously after 2 bytes written -> outputs 0 immediately; after release, no bytes until a new dist_valid, and the next record is complete and correct.
